fp_ack_parser: RTL and testbench

Receive-side parser for the fingerprint module's acknowledge packets. It consumes the byte stream from the fingerprint UART receiver (`fp_rx_byte` / `fp_rx_ready`) and validates header, address, packet ID, length and checksum. It extracts the confirmation code, page ID and match score. It produces a qualified `fp_verified` level and per-packet strobes for the voting FSM, replacing the raw "any 0x00 byte" check.

---
 rtl/fp_ack_parser.sv | 164 ++++++++++++++++
 tb/tb_fp_ack_parser.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_ack_parser.sv
// fp_ack_parser: validates fingerprint-module acknowledge packets and extracts code, page ID and score.
// Ports: fp_clk, reset_n (async, active-low); fp_rx_byte/fp_rx_ready byte stream in; clear (sync abort);
// ack_valid/pkt_error one-cycle verdict pulses; ack_code, page_id, match_score fields of the last good packet;
// fp_verified match level; err_cause last rejection reason (1 ADDR, 2 PID, 3 LEN, 4 SUM, 5 TIMEOUT).
// Macro FP_ACK_SCORE_CHECK_EN: when defined, a verified match also needs match_score >= MIN_SCORE.
module fp_ack_parser #(
  parameter logic [31:0] DEV_ADDR       = 32'hFFFF_FFFF,
  parameter int          MAX_LEN        = 16,
  parameter logic [15:0] MIN_SCORE      = 16'd50,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        fp_clk,
  input  logic        reset_n,
  input  logic [7:0]  fp_rx_byte,
  input  logic        fp_rx_ready,
  input  logic        clear,
  output logic        ack_valid,
  output logic [7:0]  ack_code,
  output logic [15:0] page_id,
  output logic [15:0] match_score,
  output logic        fp_verified,
  output logic        pkt_error,
  output logic [2:0]  err_cause
);
  typedef enum logic [3:0] {
    S_HDR0, S_HDR1, S_ADDR, S_PID, S_LEN_H, S_LEN_L, S_DATA, S_SUM_H, S_SUM_L
  } state_t;
  state_t      state, state_nx;
  logic [15:0] idx;
  logic [15:0] len;
  logic [15:0] sum;
  logic [7:0]  sum_h;
  logic [31:0] idle;
  logic [7:0]  sh_code;
  logic [15:0] sh_page;
  logic [15:0] sh_score;
  logic [2:0]  err_nx;
  logic        acc;
  logic        timeout;
  logic        match;
  logic [7:0]  dev_b;
  logic [15:0] len_word;
  assign dev_b = idx[1:0] == 2'd0 ? DEV_ADDR[31:24] :
                 idx[1:0] == 2'd1 ? DEV_ADDR[23:16] :
                 idx[1:0] == 2'd2 ? DEV_ADDR[15:8]  : DEV_ADDR[7:0];
  assign len_word = {len[15:8], fp_rx_byte};
  // idle holds the number of silent cycles already seen; this cycle would make it TIMEOUT_CYCLES
  assign timeout = state != S_HDR0 && !fp_rx_ready && idle == 32'(TIMEOUT_CYCLES - 1);
`ifdef FP_ACK_SCORE_CHECK_EN
  assign match = sh_code == 8'h00 && sh_score >= MIN_SCORE;
`else
  assign match = sh_code == 8'h00;
  logic unused_min_score;
  assign unused_min_score = ^MIN_SCORE;
`endif
  always_comb begin
    state_nx = state;
    err_nx   = 3'd0;
    acc      = 1'b0;
    if (clear) begin
      state_nx = S_HDR0;
    end else if (fp_rx_ready) begin
      case (state)
        S_HDR0:  state_nx = fp_rx_byte == 8'hEF ? S_HDR1 : S_HDR0;
        S_HDR1:  state_nx = fp_rx_byte == 8'h01 ? S_ADDR : fp_rx_byte == 8'hEF ? S_HDR1 : S_HDR0;
        S_ADDR: begin
          err_nx   = fp_rx_byte != dev_b ? 3'd1 : 3'd0;
          state_nx = fp_rx_byte != dev_b ? S_HDR0 : idx[1:0] == 2'd3 ? S_PID : S_ADDR;
        end
        S_PID: begin
          err_nx   = fp_rx_byte != 8'h07 ? 3'd2 : 3'd0;
          state_nx = fp_rx_byte != 8'h07 ? S_HDR0 : S_LEN_H;
        end
        S_LEN_H: state_nx = S_LEN_L;
        S_LEN_L: begin
          err_nx   = len_word < 16'd3 || len_word > 16'(MAX_LEN) ? 3'd3 : 3'd0;
          state_nx = err_nx != 3'd0 ? S_HDR0 : S_DATA;
        end
        // DATA carries LEN-2 bytes, so the last one has index LEN-3
        S_DATA:  state_nx = idx == len - 16'd3 ? S_SUM_H : S_DATA;
        S_SUM_H: state_nx = S_SUM_L;
        S_SUM_L: begin
          acc      = {sum_h, fp_rx_byte} == sum;
          err_nx   = acc ? 3'd0 : 3'd4;
          state_nx = S_HDR0;
        end
        default: state_nx = S_HDR0;
      endcase
    end else if (timeout) begin
      err_nx   = 3'd5;
      state_nx = S_HDR0;
    end
  end
  always_ff @(posedge fp_clk or negedge reset_n) begin
    if (!reset_n) state <= S_HDR0;
    else          state <= state_nx;
  end
  always_ff @(posedge fp_clk or negedge reset_n) begin
    if (!reset_n) begin
      idx      <= '0;
      len      <= '0;
      sum      <= '0;
      sum_h    <= '0;
      idle     <= '0;
      sh_code  <= '0;
      sh_page  <= '0;
      sh_score <= '0;
    end else begin
      idle <= (clear || fp_rx_ready || timeout || state == S_HDR0) ? 32'd0 : idle + 32'd1;
      if (clear) begin
        idx <= '0;
      end else if (fp_rx_ready) begin
        idx <= (state == S_ADDR || state == S_DATA) ? idx + 16'd1 : 16'd0;
        case (state)
          S_PID:   sum <= {8'h00, fp_rx_byte};
          S_LEN_H: begin
            sum        <= sum + {8'h00, fp_rx_byte};
            len[15:8]  <= fp_rx_byte;
          end
          S_LEN_L: begin
            sum      <= sum + {8'h00, fp_rx_byte};
            len[7:0] <= fp_rx_byte;
            sh_code  <= '0;
            sh_page  <= '0;
            sh_score <= '0;
          end
          S_DATA: begin
            sum <= sum + {8'h00, fp_rx_byte};
            if (idx == 16'd0) sh_code        <= fp_rx_byte;
            if (idx == 16'd1) sh_page[15:8]  <= fp_rx_byte;
            if (idx == 16'd2) sh_page[7:0]   <= fp_rx_byte;
            if (idx == 16'd3) sh_score[15:8] <= fp_rx_byte;
            if (idx == 16'd4) sh_score[7:0]  <= fp_rx_byte;
          end
          S_SUM_H: sum_h <= fp_rx_byte;
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge fp_clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_valid   <= 1'b0;
      pkt_error   <= 1'b0;
      ack_code    <= '0;
      page_id     <= '0;
      match_score <= '0;
      fp_verified <= 1'b0;
      err_cause   <= '0;
    end else begin
      ack_valid <= acc;
      pkt_error <= err_nx != 3'd0;
      if (err_nx != 3'd0) err_cause <= err_nx;
      if (acc) begin
        ack_code    <= sh_code;
        page_id     <= sh_page;
        match_score <= sh_score;
        fp_verified <= match;
      end else if (clear) begin
        fp_verified <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fp_ack_parser.sv
// tb_fp_ack_parser: scoreboard bench for fp_ack_parser with directed spec vectors and random packets.
module tb_fp_ack_parser;
  localparam int TO   = 30;
  localparam int MAXL = 16;
  logic        fp_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fp_rx_ready = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  fp_rx_byte = 8'h00;
  logic        ack_valid, fp_verified, pkt_error;
  logic [7:0]  ack_code;
  logic [15:0] page_id, match_score;
  logic [2:0]  err_cause;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit          err;
    logic [7:0]  code;
    logic [15:0] page;
    logic [15:0] score;
    logic        ver;
    logic [2:0]  cause;
    int          cyc;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0]  m_code = 0;
  logic [15:0] m_page = 0, m_score = 0;
  logic        m_ver = 0;
  logic [2:0]  m_cause = 0;
  fp_ack_parser #(.MAX_LEN(MAXL), .TIMEOUT_CYCLES(TO)) dut (
    .fp_clk(fp_clk), .reset_n(reset_n), .fp_rx_byte(fp_rx_byte), .fp_rx_ready(fp_rx_ready),
    .clear(clear), .ack_valid(ack_valid), .ack_code(ack_code), .page_id(page_id),
    .match_score(match_score), .fp_verified(fp_verified), .pkt_error(pkt_error), .err_cause(err_cause)
  );
  always #5 fp_clk = ~fp_clk;
  always @(posedge fp_clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  always @(negedge fp_clk) begin : mon
    exp_t e;
    if (reset_n && (ack_valid || pkt_error)) begin
      chk("exclusive", {63'b0, ack_valid & pkt_error}, 64'd0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event ack=%0b err=%0b cause=%0d", ack_valid, pkt_error, err_cause);
      end else begin
        e = q.pop_front();
        chk("kind", {63'b0, pkt_error}, {63'b0, e.err});
        chk("code", ack_code, e.code);
        chk("page", page_id, e.page);
        chk("score", match_score, e.score);
        chk("verified", fp_verified, e.ver);
        chk("cause", err_cause, e.cause);
        if (e.cyc >= 0) chk("latency", cyc, e.cyc);
      end
    end
  end
  function automatic exp_t snap(input bit err);
    exp_t e;
    e.err = err; e.code = m_code; e.page = m_page; e.score = m_score;
    e.ver = m_ver; e.cause = m_cause; e.cyc = -1;
    return e;
  endfunction
  function automatic logic [7:0] g(input bq_t d, input int i);
    return i < d.size() ? d[i] : 8'h00;
  endfunction
  task automatic accept(input bq_t d);
    m_code  = g(d, 0);
    m_page  = {g(d, 1), g(d, 2)};
    m_score = {g(d, 3), g(d, 4)};
`ifdef FP_ACK_SCORE_CHECK_EN
    m_ver = m_code == 8'h00 && m_score >= 16'd50;
`else
    m_ver = m_code == 8'h00;
`endif
  endtask
  task automatic strobe(input logic [7:0] b);
    fp_rx_byte = b;
    fp_rx_ready = 1'b1;
    @(posedge fp_clk); #1;
    fp_rx_ready = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge fp_clk); #1; end
  endtask
  task automatic send(input bq_t p, input bit has, input exp_t e, input int gap);
    foreach (p[i]) begin
      if (has && i == p.size() - 1) begin
        e.cyc = cyc + 1;
        q.push_back(e);
      end
      strobe(p[i]);
      if (gap > 0) idle($urandom_range(0, gap));
    end
  endtask
  task automatic mk(input bq_t d, input logic [15:0] len, input logic [15:0] sx, output bq_t p);
    logic [15:0] s;
    p = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, len[15:8], len[7:0]};
    s = 16'h0007 + {8'h00, len[15:8]} + {8'h00, len[7:0]};
    foreach (d[i]) begin
      p.push_back(d[i]);
      s = s + {8'h00, d[i]};
    end
    s = s ^ sx;
    p.push_back(s[15:8]);
    p.push_back(s[7:0]);
  endtask
  initial begin
    bq_t v_ok, v_nm, v_bs, v_lo, p, d;
    logic [15:0] l;
    int k, n;
    v_ok = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h07, 8'h00, 8'h00, 8'h05, 8'h00, 8'h64, 8'h00, 8'h77};
    v_nm = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h07, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h17};
    v_lo = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h07, 8'h00, 8'h00, 8'h05, 8'h00, 8'h31, 8'h00, 8'h44};
    v_bs = v_ok;
    v_bs[15] = 8'h78;
    idle(3);
    chk("rst_ack", ack_valid, 0);
    chk("rst_err", pkt_error, 0);
    chk("rst_code", ack_code, 0);
    chk("rst_page", page_id, 0);
    chk("rst_score", match_score, 0);
    chk("rst_ver", fp_verified, 0);
    chk("rst_cause", err_cause, 0);
    #2 reset_n = 1'b1;
    @(posedge fp_clk); #1;
    m_code = 8'h00; m_page = 16'h0005; m_score = 16'h0064; m_ver = 1'b1;
    send(v_ok, 1, snap(0), 0);
    idle(2);
    m_code = 8'h09; m_page = 16'h0000; m_score = 16'h0000; m_ver = 1'b0;
    send(v_nm, 1, snap(0), 1);
    idle(2);
    m_cause = 3'd4;
    send(v_bs, 1, snap(1), 0);
    strobe(8'h00);
    strobe(8'hEF);
    m_code = 8'h00; m_page = 16'h0005; m_score = 16'h0064; m_ver = 1'b1;
    send(v_ok, 1, snap(0), 0);
    m_cause = 3'd1;
    send('{8'hEF, 8'h01, 8'hFF, 8'hFE}, 1, snap(1), 0);
    m_score = 16'h0031;
`ifdef FP_ACK_SCORE_CHECK_EN
    m_ver = 1'b0;
`else
    m_ver = 1'b1;
`endif
    send(v_lo, 1, snap(0), 0);
    p = v_ok[0:7];
    send(p, 0, snap(0), 0);
    m_cause = 3'd5;
    q.push_back(snap(1));
    idle(TO + 5);
    chk("timeout_seen", q.size(), 0);
    q.delete();
    m_score = 16'h0064; m_ver = 1'b1;
    send(v_ok, 1, snap(0), 0);
    p = v_ok[0:9];
    send(p, 0, snap(0), 0);
    fp_rx_byte = v_ok[10];
    fp_rx_ready = 1'b1;
    clear = 1'b1;
    @(posedge fp_clk); #1;
    fp_rx_ready = 1'b0;
    clear = 1'b0;
    m_ver = 1'b0;
    chk("clear_ver", fp_verified, m_ver);
    chk("clear_code", ack_code, m_code);
    chk("clear_cause", err_cause, m_cause);
    idle(TO + 5);
    m_ver = 1'b1;
    send(v_ok, 1, snap(0), 0);
    m_code = 8'h09; m_page = 16'h0000; m_score = 16'h0000; m_ver = 1'b0;
    send(v_nm, 1, snap(0), 0);
    p = v_ok[0:4];
    send(p, 0, snap(0), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_code", ack_code, 0);
    chk("arst_cause", err_cause, 0);
    chk("arst_ver", fp_verified, 0);
    m_code = 0; m_page = 0; m_score = 0; m_ver = 0; m_cause = 0;
    #3 reset_n = 1'b1;
    @(posedge fp_clk); #1;
    m_code = 8'h00; m_page = 16'h0005; m_score = 16'h0064; m_ver = 1'b1;
    send(v_ok, 1, snap(0), 0);
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 3) == 0) strobe(8'($urandom_range(0, 8'hEE)));
      if ($urandom_range(0, 9) == 0) begin
        clear = 1'b1;
        @(posedge fp_clk); #1;
        clear = 1'b0;
        m_ver = 1'b0;
        chk("rnd_clear_ver", fp_verified, m_ver);
      end
      k = $urandom_range(0, 5);
      n = $urandom_range(1, MAXL - 2);
      d = {};
      for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
      d[0] = $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 255)) : 8'h00;
      if (n > 3 && $urandom_range(0, 1) == 0) d[3] = 8'h00;
      l = 16'(n + 2);
      if (k <= 1) begin
        mk(d, l, 16'h0000, p);
        accept(d);
        send(p, 1, snap(0), 3);
      end else if (k == 2) begin
        mk(d, l, 16'h0000, p);
        n = $urandom_range(2, 5);
        p[n] = 8'($urandom_range(0, 254));
        p = p[0:n];
        m_cause = 3'd1;
        send(p, 1, snap(1), 3);
      end else if (k == 3) begin
        mk(d, l, 16'h0000, p);
        p[6] = 8'($urandom_range(0, 254));
        if (p[6] == 8'h07) p[6] = 8'hFF;
        p = p[0:6];
        m_cause = 3'd2;
        send(p, 1, snap(1), 3);
      end else if (k == 4) begin
        l = $urandom_range(0, 1) ? 16'($urandom_range(0, 2)) : 16'($urandom_range(MAXL + 1, 16'hFFFF));
        mk(d, l, 16'h0000, p);
        p = p[0:8];
        m_cause = 3'd3;
        send(p, 1, snap(1), 3);
      end else begin
        mk(d, l, 16'($urandom_range(1, 16'hFFFF)), p);
        m_cause = 3'd4;
        send(p, 1, snap(1), 3);
      end
    end
    idle(5);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
